// File: rtl/sys_cmd_master.sv
// sys_cmd_master: host-side initiator for the system-control byte protocol.
// Takes one command, sends its frame bytes, collects the reply bytes.
// Ports:
//   CLK, RST          clock, async active-high reset
//   CMD_*             command request (valid/ready) and fields
//   TX_P_DATA/TX_D_VLD/TX_BUSY   byte stream toward the UART transmitter
//   RX_P_DATA/RX_D_VLD           byte strobes from the UART receiver
//   RSP_VLD/RSP_DATA/RSP_TIMEOUT completion result
//   BUSY              command in flight
module sys_cmd_master #(
   parameter int ADDRESS_WIDTH  = 4,
   parameter int ALU_DATA_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      CMD_VLD,
   output logic                      CMD_RDY,
   input  logic [1:0]                CMD_OP,
   input  logic [ADDRESS_WIDTH-1:0]  CMD_ADDR,
   input  logic [7:0]                CMD_WDATA,
   input  logic [7:0]                CMD_OPA,
   input  logic [7:0]                CMD_OPB,
   input  logic [3:0]                CMD_FUN,
   output logic [7:0]                TX_P_DATA,
   output logic                      TX_D_VLD,
   input  logic                      TX_BUSY,
   input  logic [7:0]                RX_P_DATA,
   input  logic                      RX_D_VLD,
   output logic                      RSP_VLD,
   output logic [ALU_DATA_WIDTH-1:0] RSP_DATA,
   output logic                      RSP_TIMEOUT,
   output logic                      BUSY
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT, S_DONE, S_TOUT
   } state_t;

   state_t state_q, state_d;

   logic [1:0]                op_q;
   logic [7:0]                addr_q, wdata_q, opa_q, opb_q;
   logic [3:0]                fun_q;
   logic [1:0]                idx_q, idx_d;
   logic [1:0]                rxn_q, rxn_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [7:0]                txd_q, txd_d;
   logic                      txv_q, txv_d;
   logic [ALU_DATA_WIDTH-1:0] rsp_q, rsp_d;
   logic                      accept;

   function automatic logic [7:0] frame_byte(
      input logic [1:0] op,
      input logic [1:0] i,
      input logic [7:0] a,
      input logic [7:0] w,
      input logic [7:0] oa,
      input logic [7:0] ob,
      input logic [3:0] f
   );
      logic [7:0] b;
      b = 8'h00;
      unique case (op)
         2'd0: b = (i == 2'd0) ? 8'hAA : (i == 2'd1) ? a : w;
         2'd1: b = (i == 2'd0) ? 8'hBB : a;
         2'd2: begin
            unique case (i)
               2'd0: b = 8'hCC;
               2'd1: b = oa;
               2'd2: b = ob;
               2'd3: b = {4'h0, f};
            endcase
         end
         2'd3: b = (i == 2'd0) ? 8'hDD : {4'h0, f};
      endcase
      return b;
   endfunction

   // index of the final frame byte
   function automatic logic [1:0] last_idx(input logic [1:0] op);
      return (op == 2'd0) ? 2'd2 : (op == 2'd2) ? 2'd3 : 2'd1;
   endfunction

   // number of reply bytes expected
   function automatic logic [1:0] rsp_len(input logic [1:0] op);
      return (op == 2'd0) ? 2'd0 : (op == 2'd1) ? 2'd1 : 2'd2;
   endfunction

   assign accept = (state_q == S_IDLE) && CMD_VLD;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         fun_q   <= '0;
      end else if (accept) begin
         op_q    <= CMD_OP;
         addr_q  <= 8'(CMD_ADDR);
         wdata_q <= CMD_WDATA;
         opa_q   <= CMD_OPA;
         opb_q   <= CMD_OPB;
         fun_q   <= CMD_FUN;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         rxn_q   <= '0;
         cnt_q   <= '0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rxn_q   <= rxn_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         rsp_q   <= rsp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rxn_d   = rxn_q;
      cnt_d   = cnt_q;
      txd_d   = txd_q;
      txv_d   = txv_q;
      rsp_d   = rsp_q;
      unique case (state_q)
         S_IDLE: begin
            if (CMD_VLD) begin
               state_d = S_SEND;
               idx_d   = 2'd0;
               rsp_d   = '0;
               txv_d   = 1'b1;
               // byte 0 comes straight from the request port so it
               // is on the wire the cycle after acceptance
               txd_d   = frame_byte(CMD_OP, 2'd0, 8'(CMD_ADDR),
                                    CMD_WDATA, CMD_OPA, CMD_OPB,
                                    CMD_FUN);
            end
         end
         S_SEND: begin
            if (!TX_BUSY) begin
               if (idx_q == last_idx(op_q)) begin
                  txv_d   = 1'b0;
                  cnt_d   = '0;
                  rxn_d   = 2'd0;
                  state_d = (rsp_len(op_q) != 2'd0) ? S_WAIT : S_DONE;
               end else begin
                  idx_d = idx_q + 2'd1;
                  txd_d = frame_byte(op_q, idx_q + 2'd1, addr_q,
                                     wdata_q, opa_q, opb_q, fun_q);
               end
            end
         end
         S_WAIT: begin
            if (RX_D_VLD) begin
               // a byte arriving on the last allowed cycle still counts
               cnt_d = '0;
               if (rxn_q == 2'd0)
                  rsp_d[7:0] = RX_P_DATA;
               else
                  rsp_d[15:8] = RX_P_DATA;
               rxn_d = rxn_q + 2'd1;
               if (rxn_q + 2'd1 == rsp_len(op_q))
                  state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(TIMEOUT_CYCLES - 1))
                  state_d = S_TOUT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_TOUT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign CMD_RDY     = (state_q == S_IDLE);
   assign BUSY        = (state_q != S_IDLE);
   assign RSP_VLD     = (state_q == S_DONE);
   assign RSP_TIMEOUT = (state_q == S_TOUT);
   assign TX_D_VLD    = txv_q;
   assign TX_P_DATA   = txd_q;
   assign RSP_DATA    = rsp_q;

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: directed bench for sys_cmd_master with a
// transaction-level reference model and per-cycle output compare.
module tb_sys_cmd_master;

   localparam int T = 1024;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CMD_VLD;
   logic        CMD_RDY;
   logic [1:0]  CMD_OP;
   logic [3:0]  CMD_ADDR;
   logic [7:0]  CMD_WDATA, CMD_OPA, CMD_OPB;
   logic [3:0]  CMD_FUN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_BUSY;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic        RSP_VLD;
   logic [15:0] RSP_DATA;
   logic        RSP_TIMEOUT;
   logic        BUSY;

   sys_cmd_master #(
      .ADDRESS_WIDTH(4),
      .ALU_DATA_WIDTH(16),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_OP(CMD_OP),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
      .CMD_OPA(CMD_OPA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA),
      .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [7:0] txlog[$];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string n, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  n, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  m_q[$];
   int          m_need = 0;
   int          m_got  = 0;
   int          m_idle = 0;
   bit          m_wait = 0;
   bit          m_rdy  = 1;
   bit          m_vld  = 0;
   bit          m_to   = 0;
   logic [15:0] m_rsp  = 16'h0;

   initial forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
         m_q.delete();
         m_need = 0; m_got = 0; m_idle = 0; m_wait = 0;
         m_rdy = 1; m_vld = 0; m_to = 0; m_rsp = 16'h0;
      end else if (m_vld || m_to) begin
         m_vld = 0; m_to = 0; m_rdy = 1;
      end else if (m_rdy) begin
         if (CMD_VLD) begin
            m_rdy = 0; m_rsp = 16'h0; m_got = 0;
            case (CMD_OP)
               2'd0: begin
                  m_q = '{8'hAA, {4'h0, CMD_ADDR}, CMD_WDATA};
                  m_need = 0;
               end
               2'd1: begin
                  m_q = '{8'hBB, {4'h0, CMD_ADDR}};
                  m_need = 1;
               end
               2'd2: begin
                  m_q = '{8'hCC, CMD_OPA, CMD_OPB, {4'h0, CMD_FUN}};
                  m_need = 2;
               end
               default: begin
                  m_q = '{8'hDD, {4'h0, CMD_FUN}};
                  m_need = 2;
               end
            endcase
         end
      end else if (m_q.size() > 0) begin
         if (!TX_BUSY) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               if (m_need == 0) m_vld = 1;
               else begin m_wait = 1; m_idle = 0; end
            end
         end
      end else if (m_wait) begin
         if (RX_D_VLD) begin
            m_rsp[8*m_got +: 8] = RX_P_DATA;
            m_got++;
            m_idle = 0;
            if (m_got == m_need) begin m_wait = 0; m_vld = 1; end
         end else begin
            m_idle++;
            if (m_idle == T) begin m_wait = 0; m_to = 1; end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge CLK);
      check("cmd_rdy", CMD_RDY, m_rdy);
      check("busy", BUSY, !m_rdy);
      check("tx_vld", TX_D_VLD, m_q.size() > 0);
      if (m_q.size() > 0) check("tx_data", TX_P_DATA, m_q[0]);
      check("rsp_vld", RSP_VLD, m_vld);
      check("rsp_timeout", RSP_TIMEOUT, m_to);
      check("rsp_data", RSP_DATA, m_rsp);
      if (!RST && TX_D_VLD && !TX_BUSY) txlog.push_back(TX_P_DATA);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] ad,
                           input logic [7:0] wd, input logic [7:0] oa,
                           input logic [7:0] ob, input logic [3:0] fn,
                           output int k);
      check("rdy_before_cmd", CMD_RDY, 1);
      CMD_OP = op; CMD_ADDR = ad; CMD_WDATA = wd;
      CMD_OPA = oa; CMD_OPB = ob; CMD_FUN = fn;
      CMD_VLD = 1'b1;
      step();
      CMD_VLD = 1'b0;
      k = cyc;
      txlog.delete();
   endtask

   task automatic wait_tx_idle(output int e);
      for (int i = 0; i < 40; i++) begin
         if (!TX_D_VLD) break;
         step();
      end
      check("tx_drop_bound", TX_D_VLD, 0);
      e = cyc;
   endtask

   task automatic wait_done(input int lim, output int c,
                            output bit v, output bit t);
      for (int i = 0; i < lim; i++) begin
         if (RSP_VLD || RSP_TIMEOUT) break;
         step();
      end
      v = RSP_VLD;
      t = RSP_TIMEOUT;
      c = cyc;
      check("rsp_event_bound", v | t, 1);
   endtask

   task automatic rx_byte(input logic [7:0] b, output int s);
      RX_P_DATA = b;
      RX_D_VLD = 1'b1;
      s = cyc;
      step();
      RX_D_VLD = 1'b0;
   endtask

   task automatic check_log(input string n, input int cnt,
                            input logic [31:0] b);
      check({n, "_len"}, 32'(txlog.size()), 32'(cnt));
      for (int i = 0; i < cnt; i++)
         if (i < txlog.size())
            check(n, txlog[i], b[31-8*i -: 8]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int k, e, c, s, s1, s2;
      bit v, t;
      RST = 1'b1;
      CMD_VLD = 0; CMD_OP = 0; CMD_ADDR = 0; CMD_WDATA = 0;
      CMD_OPA = 0; CMD_OPB = 0; CMD_FUN = 0;
      TX_BUSY = 0; RX_P_DATA = 0; RX_D_VLD = 0;
      repeat (2) step();
      check("rst_cmd_rdy", CMD_RDY, 1);
      check("rst_busy", BUSY, 0);
      check("rst_tx_vld", TX_D_VLD, 0);
      check("rst_tx_data", TX_P_DATA, 8'h00);
      check("rst_rsp_vld", RSP_VLD, 0);
      check("rst_rsp_to", RSP_TIMEOUT, 0);
      check("rst_rsp_data", RSP_DATA, 16'h0);
      RST = 1'b0;
      repeat (2) step();

      // register write
      send_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, k);
      check("wr_first_vld", TX_D_VLD, 1);
      check("wr_first_byte", TX_P_DATA, 8'hAA);
      wait_done(20, c, v, t);
      check("wr_latency", c - k, 3);
      check("wr_vld", v, 1);
      check("wr_data", RSP_DATA, 16'h0000);
      check_log("wr_frame", 3, 32'hAA053C00);
      step();
      check("wr_rdy_after", CMD_RDY, 1);

      // register read
      send_cmd(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, k);
      wait_tx_idle(e);
      check("rd_tx_cycles", e - k, 2);
      repeat (10) step();
      rx_byte(8'h7E, s);
      wait_done(5, c, v, t);
      check("rd_latency", c - s, 1);
      check("rd_vld", v, 1);
      check("rd_data", RSP_DATA, 16'h007E);
      check_log("rd_frame", 2, 32'hBB020000);
      step();

      // ALU with operands, back-pressure on byte 1, RX at limit
      send_cmd(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2, k);
      step();
      TX_BUSY = 1'b1;
      repeat (3) begin
         step();
         check("bp_hold_vld", TX_D_VLD, 1);
         check("bp_hold_data", TX_P_DATA, 8'h12);
      end
      TX_BUSY = 1'b0;
      wait_tx_idle(e);
      check("alu_tx_cycles", e - k, 7);
      check_log("alu_frame", 4, 32'hCC123402);
      repeat (T - 1) step();
      rx_byte(8'h48, s1);
      check("alu_no_tout_1", RSP_TIMEOUT, 0);
      repeat (T - 1) step();
      rx_byte(8'h03, s2);
      wait_done(5, c, v, t);
      check("alu_latency", c - s2, 1);
      check("alu_vld", v, 1);
      check("alu_to", t, 0);
      check("alu_data", RSP_DATA, 16'h0348);
      step();

      // no-operand ALU, one byte then timeout
      send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h9, k);
      wait_tx_idle(e);
      check("nop_tx_cycles", e - k, 2);
      check_log("nop_frame", 2, 32'hDD090000);
      repeat (3) step();
      rx_byte(8'hAB, s);
      wait_done(T + 20, c, v, t);
      check("tout_pulse", t, 1);
      check("tout_no_vld", v, 0);
      check("tout_latency", c - s, T + 1);
      check("tout_partial", RSP_DATA, 16'h00AB);
      step();
      check("tout_rdy_after", CMD_RDY, 1);
      check("tout_pulse_end", RSP_TIMEOUT, 0);

      // stray RX in idle, CMD_VLD during SEND
      rx_byte(8'h99, s);
      step();
      check("stray_rx_data", RSP_DATA, 16'h00AB);
      send_cmd(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, k);
      CMD_OP = 2'd0; CMD_ADDR = 4'hF; CMD_WDATA = 8'h55;
      CMD_VLD = 1'b1;
      step();
      CMD_VLD = 1'b0;
      wait_tx_idle(e);
      check("ign_tx_cycles", e - k, 2);
      repeat (2) step();
      rx_byte(8'h11, s);
      wait_done(5, c, v, t);
      check("ign_vld", v, 1);
      check("ign_data", RSP_DATA, 16'h0011);
      repeat (4) step();
      check_log("ign_frame", 2, 32'hBB030000);
      check("ign_idle", CMD_RDY, 1);

      // reset during third byte of an ALU frame
      send_cmd(2'd2, 4'h0, 8'h00, 8'h21, 8'h43, 4'h5, k);
      repeat (2) step();
      check("mid_third_byte", TX_P_DATA, 8'h43);
      #1 RST = 1'b1;
      #1;
      check("mid_rst_tx_vld", TX_D_VLD, 0);
      check("mid_rst_tx_data", TX_P_DATA, 8'h00);
      check("mid_rst_busy", BUSY, 0);
      step();
      RST = 1'b0;
      step();
      check("post_rst_rdy", CMD_RDY, 1);
      check("post_rst_tx_vld", TX_D_VLD, 0);
      check_log("mid_frame", 2, 32'hCC210000);
      send_cmd(2'd1, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, k);
      wait_tx_idle(e);
      check_log("post_rst_frame", 2, 32'hBB0A0000);
      rx_byte(8'hC3, s);
      wait_done(5, c, v, t);
      check("post_rst_data", RSP_DATA, 16'h00C3);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sys_cmd_master.md
# sys_cmd_master

Host-side command initiator for the system-control byte protocol. It accepts one command on a parallel request port and serialises it as frame bytes toward the UART transmitter. For commands that return data, it collects the response bytes from the UART receiver and returns a single assembled result, or flags a timeout. It is the initiator that drives the system controller from a test host or a master SoC.

## Interface
Parameters:
- ADDRESS_WIDTH, 4, register-file address width; must be ≤ 8; zero-extended to 8 bits on the wire.
- ALU_DATA_WIDTH, 16, ALU result width; fixed at 16 (two response bytes).
- TIMEOUT_CYCLES, 1024, maximum idle cycles allowed between response bytes, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VLD  in  1  command request; accepted on a rising edge where CMD_VLD && CMD_RDY.
- CMD_RDY  out  1  high exactly when the state is IDLE.
- CMD_OP  in  2  command select: 0 = reg write, 1 = reg read, 2 = ALU with operands, 3 = ALU no-operand.
- CMD_ADDR  in  ADDRESS_WIDTH  register address.
- CMD_WDATA  in  8  register write data.
- CMD_OPA  in  8  ALU operand A.
- CMD_OPB  in  8  ALU operand B.
- CMD_FUN  in  4  ALU function code.
- TX_P_DATA  out  8  byte to the UART transmitter.
- TX_D_VLD  out  1  byte valid; the byte is accepted on an edge with TX_D_VLD && !TX_BUSY.
- TX_BUSY  in  1  transmitter back-pressure.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  single-cycle strobe for a received byte.
- RSP_VLD  out  1  one-cycle pulse: command complete.
- RSP_DATA  out  16  response data; held until the next command is accepted.
- RSP_TIMEOUT  out  1  one-cycle pulse: response timed out.
- BUSY  out  1  asserted when the state is not IDLE.

## Operation
- On acceptance, all CMD_* inputs are captured into internal registers. The inputs are don't-care afterward.
- Frame byte sequences:
  - op 0: 0xAA, {0,ADDR}, WDATA.
  - op 1: 0xBB, {0,ADDR}.
  - op 2: 0xCC, OPA, OPB, {4'h0,FUN}.
  - op 3: 0xDD, {4'h0,FUN}.
- Expected response byte count:
  - op 0: 0.
  - op 1: 1.
  - op 2 and op 3: 2, low byte first.
- FSM states:
  - IDLE: CMD_RDY = 1. Accepting a command → SEND, with byte index 0 and RSP_DATA cleared to 0.
  - SEND: presents the byte at the current index. Each accepted byte increments the index. After the last byte is accepted: → WAIT_RSP if the expected count > 0, else → DONE.
  - WAIT_RSP: each RX_D_VLD stores RX_P_DATA into RSP_DATA, first byte in [7:0] and second in [15:8]. When the expected count is reached → DONE. If the timeout counter reaches TIMEOUT_CYCLES → TOUT.
  - DONE: RSP_VLD = 1 for one cycle → IDLE.
  - TOUT: RSP_TIMEOUT = 1 for one cycle → IDLE. RSP_DATA keeps any partial bytes already received.
- Timeout counter:
  - Cleared on entry to WAIT_RSP and on every RX_D_VLD.
  - Otherwise increments by 1 each cycle in WAIT_RSP.
  - Width is clog2(TIMEOUT_CYCLES+1).
- RX_D_VLD outside WAIT_RSP is ignored; RSP_DATA is unchanged.
- CMD_VLD while not in IDLE is ignored, with no side effects.
- Reset values:
  - CMD_RDY = 1, BUSY = 0.
  - TX_D_VLD = 0, TX_P_DATA = 0.
  - RSP_VLD = 0, RSP_TIMEOUT = 0, RSP_DATA = 0.
  - State = IDLE, index = 0, counter = 0.

## Timing
- TX_P_DATA and TX_D_VLD are registered.
- If the command is accepted at edge k, TX_D_VLD is high from cycle k+1 with byte 0.
- While TX_BUSY = 1, TX_D_VLD stays high and TX_P_DATA is held stable.
- After an accepting edge, the next byte appears in the following cycle. TX_D_VLD stays high with no gap between bytes of one frame.
- After the last byte is accepted, TX_D_VLD drops in the next cycle.
- Byte throughput with TX_BUSY held low: 1 byte per cycle.
- RSP_VLD pulses in the cycle after:
  - the final RX byte's sampling edge (ops 1–3), or
  - the final TX acceptance edge (op 0).
- A new command can be accepted on the edge that ends the DONE or TOUT cycle + 1; that is, CMD_RDY is high in the cycle after the pulse.
- Simultaneous RX_D_VLD and counter = TIMEOUT_CYCLES−1: the byte wins and the counter clears.
- RST asserted mid-frame: all outputs return to reset values immediately (asynchronously). The partial frame is abandoned with no further TX bytes. Frame bytes are never resumed after reset.

## Test plan
- Write op 0, ADDR = 0x5, WDATA = 0x3C, TX_BUSY = 0 → TX bytes AA, 05, 3C on 3 consecutive cycles starting at k+1. RSP_VLD pulses at k+4 with RSP_DATA = 0x0000.
- Read op 1, ADDR = 0x2, then RX byte 0x7E strobed 10 cycles later → TX bytes BB, 02. RSP_VLD pulses 1 cycle after the RX strobe with RSP_DATA = 0x007E.
- ALU op 2, OPA = 0x12, OPB = 0x34, FUN = 0x2, with TX_BUSY high for 3 cycles on byte 1 → TX bytes CC, 12, 34, 02. Byte 0x12 is held stable during back-pressure. RX bytes 0x48, 0x03 → RSP_DATA = 0x0348.
- No-operand ALU op 3, FUN = 0x9, with only one RX byte 0xAB delivered → after TIMEOUT_CYCLES idle cycles, RSP_TIMEOUT pulses, RSP_VLD stays 0, RSP_DATA = 0x00AB, CMD_RDY = 1 in the next cycle.
- CMD_VLD pulsed during SEND with different fields, plus a stray RX_D_VLD in IDLE → the ignored command never appears on TX and RSP_DATA is unchanged.
- RST asserted during the third byte of an op 2 frame → TX_D_VLD = 0 immediately and CMD_RDY = 1 after release. The next op 1 command produces a clean BB frame.
